// File: rtl/error_monitor.sv
// -----------------------------------------------------------------------------
// error_monitor
//
// Watches a raw, asynchronous sensor error flag, brings it into the clk domain
// through a two-flop synchronizer, debounces it and raises a latched alarm once
// the synchronized flag has been high for DEBOUNCE_CYCLES consecutive samples.
// The alarm stays up until it is acknowledged with clear while the
// synchronized flag is low. Every alarm event is counted in a saturating
// 8-bit counter.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive synchronized-high samples needed to raise
//                    the alarm (legal range 2..15)
//
// Ports
//   clk          in   system clock, rising-edge
//   n_rst        in   asynchronous active-low reset
//   error_in     in   raw sensor error flag, asynchronous to clk
//   clear        in   alarm acknowledge, synchronous, level-sensitive
//   error_sync   out  error_in after the two-flop synchronizer
//   alarm        out  debounced, latched alarm (registered)
//   event_count  out  alarm events since reset, saturating at 255 (registered)
// -----------------------------------------------------------------------------
module error_monitor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       error_in,
    input  logic       clear,
    output logic       error_sync,
    output logic       alarm,
    output logic [7:0] event_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        ALARM   = 2'd2
    } state_t;

    // dcnt value at which the current sample is the DEBOUNCE_CYCLES-th one
    localparam logic [3:0] DCNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Synchronizer
    // -------------------------------------------------------------------------
    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = error_in;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign error_sync = s2_q;

    // -------------------------------------------------------------------------
    // Debounce FSM
    // -------------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [3:0] dcnt_q, dcnt_d;
    logic       alarm_q, alarm_d;
    logic [7:0] event_count_q, event_count_d;
    logic       raise;

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        raise   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = CONFIRM;
                    dcnt_d  = 4'd1;
                end else begin
                    dcnt_d  = 4'd0;
                end
            end

            CONFIRM: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    dcnt_d  = 4'd0;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = ALARM;
                    dcnt_d  = 4'd0;
                    raise   = 1'b1;
                end else begin
                    dcnt_d  = dcnt_q + 4'd1;
                end
            end

            ALARM: begin
                // Acknowledge only takes effect once the error has gone away,
                // so a still-present error cannot be silenced.
                if (clear && !s2_q) begin
                    state_d = IDLE;
                    dcnt_d  = 4'd0;
                end
            end

            default: begin
                state_d = IDLE;
                dcnt_d  = 4'd0;
            end
        endcase
    end

    // alarm is registered from the next state so it is glitch-free and
    // coincides exactly with the FSM being in ALARM.
    always_comb begin
        alarm_d       = (state_d == ALARM);
        event_count_d = event_count_q;
        if (raise && (event_count_q != 8'hFF)) begin
            event_count_d = event_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            dcnt_q        <= 4'd0;
            alarm_q       <= 1'b0;
            event_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            dcnt_q        <= dcnt_d;
            alarm_q       <= alarm_d;
            event_count_q <= event_count_d;
        end
    end

    assign alarm       = alarm_q;
    assign event_count = event_count_q;

endmodule

// File: tb/tb_error_monitor.sv
// -----------------------------------------------------------------------------
// tb_error_monitor
//
// Self-checking bench for error_monitor. A behavioural reference model is
// advanced on every clock edge; its predicted outputs are queued when the
// stimulus for that edge is applied and popped/compared on the following
// falling edge. Directed constant checks cover latency, glitch rejection,
// acknowledge behaviour, reset and counter saturation.
// -----------------------------------------------------------------------------
module tb_error_monitor;

    localparam int DEB = 4;

    logic       clk;
    logic       n_rst;
    logic       error_in;
    logic       clear;
    logic       error_sync;
    logic       alarm;
    logic [7:0] event_count;

    error_monitor #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .error_in    (error_in),
        .clear       (clear),
        .error_sync  (error_sync),
        .alarm       (alarm),
        .event_count (event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       sync;
        logic       alarm;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic       m_s1, m_s2, m_alarm;
    int         m_run;
    logic [7:0] m_cnt;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1    = 1'b0;
        m_s2    = 1'b0;
        m_alarm = 1'b0;
        m_run   = 0;
        m_cnt   = 8'd0;
        exp_q.delete();
    endtask

    // One clock edge of the reference: debounce uses the synchronized value
    // that was present before the edge, then the synchronizer shifts.
    task automatic model_tick(input logic ein, input logic clr);
        if (!m_alarm) begin
            if (m_s2) begin
                if (m_run == DEB - 1) begin
                    m_alarm = 1'b1;
                    m_run   = 0;
                    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                end else begin
                    m_run = m_run + 1;
                end
            end else begin
                m_run = 0;
            end
        end else if (clr && !m_s2) begin
            m_alarm = 1'b0;
        end
        m_s2 = m_s1;
        m_s1 = ein;
    endtask

    // Called at a falling edge: drive, clock once, score on the next fall.
    task automatic step(input logic ein, input logic clr);
        exp_t e;
        error_in = ein;
        clear    = clr;
        @(posedge clk);
        model_tick(ein, clr);
        exp_q.push_back('{sync: m_s2, alarm: m_alarm, cnt: m_cnt});
        @(negedge clk);
        e = exp_q.pop_front();
        chk("sync",  {7'd0, error_sync}, {7'd0, e.sync});
        chk("alarm", {7'd0, alarm},      {7'd0, e.alarm});
        chk("count", event_count,        e.cnt);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic mid_reset();
        #2;
        n_rst = 1'b0;
        model_reset();
        #1;
        chk("rst_sync",  {7'd0, error_sync}, 8'd0);
        chk("rst_alarm", {7'd0, alarm},      8'd0);
        chk("rst_count", event_count,        8'd0);
        chk("rst_dcnt",  {4'd0, dut.dcnt_q}, 8'd0);
        chk("rst_state", {6'd0, dut.state_q}, 8'd0);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst    = 1'b0;
        error_in = 1'b1;
        clear    = 1'b0;
        model_reset();
        #1;
        // reset state before any clock edge, error_in already high
        chk("por_sync",  {7'd0, error_sync}, 8'd0);
        chk("por_alarm", {7'd0, alarm},      8'd0);
        chk("por_count", event_count,        8'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // latency: error_in high from before edge 1
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b0);
            if (i == 1) chk("lat_sync1", {7'd0, error_sync}, 8'd0);
            if (i == 2) chk("lat_sync2", {7'd0, error_sync}, 8'd1);
            if (i == 5) chk("lat_e5", {7'd0, alarm}, 8'd0);
        end
        chk("lat_e6", {7'd0, alarm}, 8'd1);
        chk("lat_cnt", event_count, 8'd1);

        // clear while error persists keeps the alarm
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        chk("clr_hold", {7'd0, alarm}, 8'd1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("clr_sync0", {7'd0, error_sync}, 8'd0);
        chk("clr_pre",   {7'd0, alarm},      8'd1);
        step(1'b0, 1'b1);
        chk("clr_drop",  {7'd0, alarm},      8'd0);
        chk("clr_cnt",   event_count,        8'd1);

        // 3-cycle glitch with clear held: no alarm, back to IDLE
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        chk("gl_alarm", {7'd0, alarm}, 8'd0);
        chk("gl_cnt",   event_count,   8'd1);
        chk("gl_idle",  {6'd0, dut.state_q}, 8'd0);

        // fresh confirm sequence needs the full count, clear ignored
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b1);
            if (i == 5) chk("re_e5", {7'd0, alarm}, 8'd0);
        end
        chk("re_e6",  {7'd0, alarm}, 8'd1);
        chk("re_cnt", event_count,   8'd2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        chk("re_clr", {7'd0, alarm}, 8'd0);

        // reset in CONFIRM with dcnt=2
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        chk("cf_dcnt", {4'd0, dut.dcnt_q}, 8'd2);
        mid_reset();
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b0);
            if (i == 5) chk("pr_e5", {7'd0, alarm}, 8'd0);
        end
        chk("pr_e6",  {7'd0, alarm}, 8'd1);
        chk("pr_cnt", event_count,   8'd1);

        // reset while in ALARM
        mid_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("ar_alarm", {7'd0, alarm}, 8'd0);

        // saturation: 260 alarm/clear cycles
        for (int n = 0; n < 260; n++) begin
            for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
            for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
            if (n == 254) chk("sat_255", event_count, 8'hFF);
        end
        chk("sat_hold",  event_count, 8'hFF);
        chk("sat_alarm", {7'd0, alarm}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
